// File: rtl/ola_pkg.sv
// rtl/ola_pkg.sv - shared constants, state type and saturation helper for ola_synth128
//
// Purpose: frame geometry (N_FFT, HOP), sample width W, the controller state
// type and the 17-to-16 bit saturating narrow used on the overlap-add sum.
// Ports: none (package).

package ola_pkg;

  localparam int N_FFT = 128;
  localparam int HOP   = 64;
  localparam int W     = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2,
    DONE  = 2'd3
  } state_t;

  // The two top bits of a 17-bit sum disagree only on overflow; the MSB then
  // tells which rail to clamp to.
  function automatic logic signed [W-1:0] sat16(input logic signed [W:0] v);
    if (v[W] != v[W-1]) begin
      return v[W] ? 16'sh8000 : 16'sh7fff;
    end
    return v[W-1:0];
  endfunction

endpackage

// File: rtl/ola_tail_ram.sv
// rtl/ola_tail_ram.sv - 64 x 16 tail store with one write port and async read
//
// Purpose: holds the second half of the previous frame. Contents are never
// reset; the controller masks stale data with its tail_valid flag.
// Ports:
//   clock  in   write clock
//   we     in   write enable
//   waddr  in   6-bit write address
//   wdata  in   16-bit write data
//   raddr  in   6-bit read address
//   rdata  out  16-bit combinational read data

module ola_tail_ram
  import ola_pkg::*;
(
  input  logic         clock,
  input  logic         we,
  input  logic [5:0]   waddr,
  input  logic [W-1:0] wdata,
  input  logic [5:0]   raddr,
  output logic [W-1:0] rdata
);

  logic [W-1:0] mem [HOP];

  always_ff @(posedge clock) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/ola_synth128.sv
// rtl/ola_synth128.sv - 128-point / hop-64 overlap-add synthesis with tail flush
//
// Purpose: adds the first half of each IFFT frame to the stored second half
// of the previous frame and emits 64 real samples per frame; on flush the
// last stored half is drained, then done pulses.
// Ports:
//   clock       in   rising-edge clock
//   reset       in   synchronous active-high reset
//   di_en       in   input sample strobe
//   di_re       in   16-bit signed real sample
//   di_im       in   16-bit imaginary sample (unused)
//   flush       in   end-of-stream pulse
//   dout        out  16-bit signed reconstructed sample (registered)
//   dout_valid  out  qualifies dout
//   done        out  one-cycle pulse after the final tail sample
//   busy        out  high while in RUN or FLUSH

module ola_synth128
  import ola_pkg::*;
#(
  parameter int SCALE_SHIFT = 0
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         di_en,
  input  logic [W-1:0] di_re,
  input  logic [W-1:0] di_im,
  input  logic         flush,
  output logic [W-1:0] dout,
  output logic         dout_valid,
  output logic         done,
  output logic         busy
);

  state_t             state;
  logic [6:0]         k;
  logic [6:0]         fidx;
  logic               pending;
  logic               tail_valid;

  logic               accept;
  logic               we;
  logic [5:0]         raddr;
  logic [W-1:0]       rdata;
  logic signed [W-1:0] x;
  logic signed [W-1:0] tail_rd;
  logic signed [W:0]   sum;
  logic               unused_im;

  assign unused_im = ^di_im;

  always_comb begin
    x       = $signed(di_re) >>> SCALE_SHIFT;
    raddr   = (state == FLUSH) ? fidx[5:0] : k[5:0];
    tail_rd = tail_valid ? rdata : '0;
    sum     = {tail_rd[W-1], tail_rd} + {x[W-1], x};
    // A flush arriving at a frame boundary takes precedence over a sample in
    // the same cycle, so that sample is not consumed.
    accept  = di_en && (((state == IDLE) && !flush) ||
                        ((state == RUN) && !(flush && (k == 7'd0))));
    we      = accept && k[6];
  end

  ola_tail_ram u_tail (
    .clock (clock),
    .we    (we),
    .waddr (k[5:0]),
    .wdata (x),
    .raddr (raddr),
    .rdata (rdata)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= IDLE;
      k          <= '0;
      fidx       <= '0;
      pending    <= 1'b0;
      tail_valid <= 1'b0;
      dout       <= '0;
      dout_valid <= 1'b0;
      done       <= 1'b0;
      busy       <= 1'b0;
    end else begin
      dout_valid <= 1'b0;
      done       <= 1'b0;

      if (accept) begin
        k <= k + 7'd1;
        if (!k[6]) begin
          dout       <= sat16(sum);
          dout_valid <= 1'b1;
        end
        if (k == 7'd127) begin
          tail_valid <= 1'b1;
        end
      end

      case (state)
        IDLE: begin
          if (flush) begin
            state <= FLUSH;
            fidx  <= '0;
            busy  <= 1'b1;
          end else if (di_en) begin
            state <= RUN;
            busy  <= 1'b1;
          end
        end
        RUN: begin
          if (flush && (k == 7'd0)) begin
            state   <= FLUSH;
            fidx    <= '0;
            pending <= 1'b0;
          end else if (accept && (k == 7'd127) && (pending || flush)) begin
            state   <= FLUSH;
            fidx    <= '0;
            pending <= 1'b0;
          end else if (flush) begin
            pending <= 1'b1;
          end
        end
        FLUSH: begin
          // fidx runs one past the last tail entry so done lands the cycle
          // after the 64th output; with no stored frame it ends at once.
          if (!tail_valid || (fidx == 7'd64)) begin
            state <= DONE;
            done  <= 1'b1;
            busy  <= 1'b0;
          end else begin
            dout       <= rdata;
            dout_valid <= 1'b1;
            fidx       <= fidx + 7'd1;
          end
        end
        DONE: begin
          state      <= IDLE;
          k          <= '0;
          pending    <= 1'b0;
          tail_valid <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
